// File: rtl/mc_sequencer_if.sv
// ---------------------------------------------------------------------------
// mc_sequencer_if
//   Bundles the sequencer's instruction-fetch handshake and its register-file
//   read/write ports.
//   master modport (sequencer side):
//     out: imem_req, pc, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data
//     in : imem_ack, imem_data, rf_rd_data
//   slave modport (memory / register-file side): mirror of master.
// ---------------------------------------------------------------------------
interface mc_sequencer_if #(
  parameter int ADDRESS_LEN = 4,
  parameter int DATA_LEN    = 16,
  parameter int PC_LEN      = 8
) ();
  logic                   imem_req;
  logic                   imem_ack;
  logic [DATA_LEN-1:0]    imem_data;
  logic [PC_LEN-1:0]      pc;
  logic [ADDRESS_LEN-1:0] rf_rd_addr;
  logic [DATA_LEN-1:0]    rf_rd_data;
  logic                   rf_wr_en;
  logic [ADDRESS_LEN-1:0] rf_wr_addr;
  logic [DATA_LEN-1:0]    rf_wr_data;

  modport master (
    output imem_req, pc, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
    input  imem_ack, imem_data, rf_rd_data
  );

  modport slave (
    input  imem_req, pc, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
    output imem_ack, imem_data, rf_rd_data
  );
endinterface

// File: rtl/mc_sequencer.sv
// ---------------------------------------------------------------------------
// mc_sequencer
//   Multi-cycle micro-sequencer: fetches 16-bit instructions, reads up to two
//   register operands one per cycle, executes ADD/SUB/AND/OR/LDI/JMP/NOP/HALT
//   and writes the result back through a single register-file write port.
//   Ports:
//     clk     - rising-edge clock
//     rst     - asynchronous active-low reset
//     bus     - mc_sequencer_if.master (fetch handshake + register-file ports)
//     halted  - high while the sequencer sits in HALTED
//     illegal - one-cycle pulse while an undefined opcode is being decoded
//   Every output comes straight from a flop; the output flops are loaded from
//   the next-state values so each output lines up with the state it belongs to.
// ---------------------------------------------------------------------------
module mc_sequencer #(
  parameter int ADDRESS_LEN = 4,
  parameter int DATA_LEN    = 16,
  parameter int PC_LEN      = 8
) (
  input  logic           clk,
  input  logic           rst,
  mc_sequencer_if.master bus,
  output logic           halted,
  output logic           illegal
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_READ_A = 3'd3,
    ST_READ_B = 3'd4,
    ST_EXEC   = 3'd5,
    ST_WB     = 3'd6,
    ST_HALTED = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [PC_LEN-1:0]      PC_ONE    = {{(PC_LEN-1){1'b0}}, 1'b1};
  localparam logic [PC_LEN-1:0]      PC_ZERO   = {PC_LEN{1'b0}};
  localparam logic [DATA_LEN-1:0]    DATA_ZERO = {DATA_LEN{1'b0}};
  localparam logic [ADDRESS_LEN-1:0] ADDR_ZERO = {ADDRESS_LEN{1'b0}};

  // Opcodes 0x7..0xE are undefined and decode as a NOP with an illegal pulse.
  function automatic logic op_is_illegal(input logic [3:0] op);
    logic res;
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI, OP_JMP, OP_HALT: res = 1'b0;
      default:                                                        res = 1'b1;
    endcase
    return res;
  endfunction

  // Two-operand ALU; results wrap modulo 2^DATA_LEN.
  function automatic logic [DATA_LEN-1:0] alu(input logic [3:0]          op,
                                                input logic [DATA_LEN-1:0] a,
                                                input logic [DATA_LEN-1:0] b);
    logic [DATA_LEN-1:0] res;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      default: res = DATA_ZERO;
    endcase
    return res;
  endfunction

  state_t              state_r,  state_s;
  logic [PC_LEN-1:0]   pc_r,     pc_s;
  logic [DATA_LEN-1:0] instr_r,  instr_s;
  logic [DATA_LEN-1:0] opa_r,    opa_s;
  logic [DATA_LEN-1:0] opb_r,    opb_s;
  logic [DATA_LEN-1:0] result_r, result_s;

  logic                   imem_req_r,   imem_req_s;
  logic [ADDRESS_LEN-1:0] rf_rd_addr_r, rf_rd_addr_s;
  logic                   rf_wr_en_r,   rf_wr_en_s;
  logic [ADDRESS_LEN-1:0] rf_wr_addr_r, rf_wr_addr_s;
  logic [DATA_LEN-1:0]    rf_wr_data_r, rf_wr_data_s;
  logic                   halted_r,     halted_s;
  logic                   illegal_r,    illegal_s;

  logic [3:0] op_r;
  logic [7:0] imm_r;

  assign op_r  = instr_r[15:12];
  assign imm_r = instr_r[7:0];

  // Next-state and datapath register updates.
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    instr_s  = instr_r;
    opa_s    = opa_r;
    opb_s    = opb_r;
    result_s = result_r;
    case (state_r)
      ST_IDLE: state_s = ST_FETCH;
      ST_FETCH: begin
        if (bus.imem_ack) begin
          instr_s = bus.imem_data;
          pc_s    = pc_r + PC_ONE;
          state_s = ST_DECODE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (op_r)
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_s = ST_READ_A;
          OP_LDI: begin
            result_s = DATA_LEN'(imm_r);
            state_s  = ST_WB;
          end
          OP_JMP: begin
            pc_s    = PC_LEN'(imm_r);
            state_s = ST_FETCH;
          end
          OP_HALT: state_s = ST_HALTED;
          // NOP and undefined opcodes both return to fetch.
          default: state_s = ST_FETCH;
        endcase
      end
      ST_READ_A: begin
        opa_s   = bus.rf_rd_data;
        state_s = ST_READ_B;
      end
      ST_READ_B: begin
        opb_s   = bus.rf_rd_data;
        state_s = ST_EXEC;
      end
      ST_EXEC: begin
        result_s = alu(op_r, opa_r, opb_r);
        state_s  = ST_WB;
      end
      ST_WB:     state_s = ST_FETCH;
      ST_HALTED: state_s = ST_HALTED;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Output values for the state being entered, so the output flops track state.
  // instr_s is used for the register fields because it already holds the
  // instruction that the entered state works on.
  always_comb begin
    imem_req_s   = 1'b0;
    rf_rd_addr_s = ADDR_ZERO;
    rf_wr_en_s   = 1'b0;
    rf_wr_addr_s = ADDR_ZERO;
    rf_wr_data_s = DATA_ZERO;
    halted_s     = 1'b0;
    illegal_s    = 1'b0;
    case (state_s)
      ST_FETCH:  imem_req_s   = 1'b1;
      ST_DECODE: illegal_s    = op_is_illegal(instr_s[15:12]);
      ST_READ_A: rf_rd_addr_s = ADDRESS_LEN'(instr_s[7:4]);
      ST_READ_B: rf_rd_addr_s = ADDRESS_LEN'(instr_s[3:0]);
      ST_WB: begin
        rf_wr_en_s   = 1'b1;
        rf_wr_addr_s = ADDRESS_LEN'(instr_s[11:8]);
        rf_wr_data_s = result_s;
      end
      ST_HALTED: halted_s = 1'b1;
      default:   imem_req_s = 1'b0;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      pc_r     <= PC_ZERO;
      instr_r  <= DATA_ZERO;
      opa_r    <= DATA_ZERO;
      opb_r    <= DATA_ZERO;
      result_r <= DATA_ZERO;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      instr_r  <= instr_s;
      opa_r    <= opa_s;
      opb_r    <= opb_s;
      result_r <= result_s;
    end
  end

  // Output registers; reset clears them asynchronously, aborting any write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_req_r   <= 1'b0;
      rf_rd_addr_r <= ADDR_ZERO;
      rf_wr_en_r   <= 1'b0;
      rf_wr_addr_r <= ADDR_ZERO;
      rf_wr_data_r <= DATA_ZERO;
      halted_r     <= 1'b0;
      illegal_r    <= 1'b0;
    end else begin
      imem_req_r   <= imem_req_s;
      rf_rd_addr_r <= rf_rd_addr_s;
      rf_wr_en_r   <= rf_wr_en_s;
      rf_wr_addr_r <= rf_wr_addr_s;
      rf_wr_data_r <= rf_wr_data_s;
      halted_r     <= halted_s;
      illegal_r    <= illegal_s;
    end
  end

  assign bus.imem_req   = imem_req_r;
  assign bus.pc         = pc_r;
  assign bus.rf_rd_addr = rf_rd_addr_r;
  assign bus.rf_wr_en   = rf_wr_en_r;
  assign bus.rf_wr_addr = rf_wr_addr_r;
  assign bus.rf_wr_data = rf_wr_data_r;
  assign halted         = halted_r;
  assign illegal        = illegal_r;

endmodule

// File: tb/tb_mc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mc_sequencer
//   Drives mc_sequencer through a directed program followed by randomized
//   instructions and fetch-acknowledge timing. An instruction-level model
//   (architectural register file + per-instruction cycle schedule) predicts
//   every output on every cycle; directed instructions also get literal checks.
// ---------------------------------------------------------------------------
module tb_mc_sequencer;
  localparam int AL   = 4;
  localparam int DL   = 16;
  localparam int PL   = 8;
  localparam int HIST = 8192;

  logic clk = 1'b0;
  logic rst;
  logic halted, illegal;

  mc_sequencer_if #(.ADDRESS_LEN(AL), .DATA_LEN(DL), .PC_LEN(PL)) bus ();

  mc_sequencer #(.ADDRESS_LEN(AL), .DATA_LEN(DL), .PC_LEN(PL)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .halted  (halted),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // Register file seen by the sequencer; combinational read.
  logic [15:0] arch_rf [16];
  assign bus.rf_rd_data = arch_rf[bus.rf_rd_addr];

  typedef struct packed {
    logic        req;
    logic [7:0]  pc;
    logic [3:0]  rd_addr;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        halted;
    logic        illegal;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m_pc;
  bit         m_halted;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_aborts = 0;

  logic [7:0]  pc_hist  [HIST];
  logic        req_hist [HIST];
  logic [3:0]  rd_hist  [HIST];
  logic        wen_hist [HIST];
  logic [3:0]  wad_hist [HIST];
  logic [15:0] wdt_hist [HIST];
  logic        ill_hist [HIST];
  logic        hlt_hist [HIST];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t blank(input logic [7:0] p);
    exp_t e;
    e    = '0;
    e.pc = p;
    return e;
  endfunction

  function automatic logic [15:0] rnd16();
    logic [31:0] r;
    r = $urandom();
    return r[15:0];
  endfunction

  function automatic logic [15:0] rnd_instr();
    logic [31:0] r;
    logic [3:0]  op;
    int          sel;
    r   = $urandom();
    sel = $urandom_range(0, 19);
    if (sel < 10)      op = 4'(1 + sel % 4);
    else if (sel < 13) op = 4'h5;
    else if (sel < 15) op = 4'h6;
    else if (sel == 15) op = 4'h0;
    else if (sel < 19) op = 4'($urandom_range(7, 14));
    else               op = 4'hF;
    return {op, r[11:0]};
  endfunction

  // Expected outputs for the cycle in progress.
  function automatic exp_t cur_exp();
    exp_t e;
    if (q.size() > 0) begin
      e = q[0];
    end else begin
      e = blank(m_pc);
      if (m_halted) e.halted = 1'b1;
      else          e.req    = 1'b1;
    end
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc     = 8'h00;
    m_halted = 1'b0;
    q.push_back(blank(8'h00));   // the idle cycle after reset release
  endtask

  // Instruction accepted: queue the cycles it occupies after the fetch cycle.
  task automatic decode(input logic [15:0] ins);
    logic [3:0]  op, rd, rs, rt;
    logic [15:0] a, b, r;
    exp_t        e;
    op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    m_pc = m_pc + 8'd1;
    e = blank(m_pc);
    e.illegal = (op >= 4'h7) && (op <= 4'hE);
    q.push_back(e);
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4: begin
        a = arch_rf[rs];
        b = arch_rf[rt];
        case (op)
          4'h1:    r = a + b;
          4'h2:    r = a - b;
          4'h3:    r = a & b;
          default: r = a | b;
        endcase
        e = blank(m_pc); e.rd_addr = rs; q.push_back(e);
        e = blank(m_pc); e.rd_addr = rt; q.push_back(e);
        e = blank(m_pc);                 q.push_back(e);
        e = blank(m_pc); e.wr_en = 1'b1; e.wr_addr = rd; e.wr_data = r; q.push_back(e);
      end
      4'h5: begin
        e = blank(m_pc); e.wr_en = 1'b1; e.wr_addr = rd; e.wr_data = {8'h00, ins[7:0]};
        q.push_back(e);
      end
      4'h6:    m_pc = ins[7:0];
      4'hF:    m_halted = 1'b1;
      default: ;
    endcase
  endtask

  task automatic model_advance(input logic ack, input logic [15:0] data);
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.wr_en) arch_rf[e.wr_addr] = e.wr_data;
    end else if (!m_halted && ack) begin
      decode(data);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"},   32'(bus.imem_req),   32'h0);
    check({tag, "_pc"},         32'(bus.pc),         32'h0);
    check({tag, "_rf_rd_addr"}, 32'(bus.rf_rd_addr), 32'h0);
    check({tag, "_rf_wr_en"},   32'(bus.rf_wr_en),   32'h0);
    check({tag, "_rf_wr_addr"}, 32'(bus.rf_wr_addr), 32'h0);
    check({tag, "_rf_wr_data"}, 32'(bus.rf_wr_data), 32'h0);
    check({tag, "_halted"},     32'(halted),         32'h0);
    check({tag, "_illegal"},    32'(illegal),        32'h0);
  endtask

  // Assert reset right now, check outputs clear at once, release after a posedge.
  task automatic reset_pulse(input string tag);
    rst = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic compare_all(input exp_t e);
    check("imem_req",   32'(bus.imem_req),   32'(e.req));
    check("pc",         32'(bus.pc),         32'(e.pc));
    check("rf_rd_addr", 32'(bus.rf_rd_addr), 32'(e.rd_addr));
    check("rf_wr_en",   32'(bus.rf_wr_en),   32'(e.wr_en));
    check("halted",     32'(halted),         32'(e.halted));
    check("illegal",    32'(illegal),        32'(e.illegal));
    if (e.wr_en) begin
      check("rf_wr_addr", 32'(bus.rf_wr_addr), 32'(e.wr_addr));
      check("rf_wr_data", 32'(bus.rf_wr_data), 32'(e.wr_data));
    end
  endtask

  // One clock cycle: compare, log, then drive this cycle's fetch inputs.
  task automatic step(input logic ack, input logic [15:0] data, input bit abort_ok);
    exp_t e;
    @(negedge clk);
    e = cur_exp();
    compare_all(e);
    if (cyc < HIST) begin
      pc_hist[cyc]  = bus.pc;       req_hist[cyc] = bus.imem_req;
      rd_hist[cyc]  = bus.rf_rd_addr;
      wen_hist[cyc] = bus.rf_wr_en; wad_hist[cyc] = bus.rf_wr_addr;
      wdt_hist[cyc] = bus.rf_wr_data;
      ill_hist[cyc] = illegal;      hlt_hist[cyc] = halted;
    end
    if (abort_ok && e.wr_en) begin
      n_aborts++;
      reset_pulse("wb_abort");
    end else begin
      bus.imem_ack  = ack;
      bus.imem_data = data;
      model_advance(ack, data);
    end
    cyc++;
  endtask

  task automatic fetch(input logic [15:0] ins, input int hold, output int ack_cyc);
    int guard;
    guard = 0;
    while ((q.size() != 0 || m_halted) && guard < 20) begin
      step(1'b0, rnd16(), 1'b0);
      guard++;
    end
    check("fetch_wait_bound", 32'(guard < 20), 32'h1);
    repeat (hold) step(1'b0, rnd16(), 1'b0);
    ack_cyc = cyc;
    step(1'b1, ins, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9, cnt, guard, halt_cnt, ab0;
    rst = 1'b1;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'h0000;
    for (int i = 0; i < 16; i++) arch_rf[i] = rnd16();
    arch_rf[1] = 16'hFFFF;
    arch_rf[2] = 16'h0002;
    @(negedge clk);
    reset_pulse("reset");

    // Directed program.
    fetch(16'h5A3C, 0, a0);                 // LDI r10,0x3C
    fetch(16'h1312, 0, a1);                 // ADD r3,r1,r2
    while (q.size() != 0) step(1'b0, rnd16(), 1'b0);
    arch_rf[1] = 16'h1234;
    fetch(16'h2011, 0, a2);                 // SUB r0,r1,r1
    fetch(16'h6080, 0, a3);                 // JMP 0x80
    fetch(16'h7000, 4, a4);                 // illegal, ack withheld 4 cycles
    fetch(16'h60FF, 0, a5);                 // JMP 0xFF
    fetch(16'h0000, 0, a6);                 // NOP at pc 0xFF
    fetch(16'h1312, 0, a7);                 // ADD, reset during its write-back
    ab0 = n_aborts;
    guard = 0;
    while (n_aborts == ab0 && guard < 10) begin
      step(1'b0, rnd16(), 1'b1);
      guard++;
    end
    check("abort_reached", 32'(n_aborts - ab0), 32'h1);
    fetch(16'h0000, 0, a8);                 // first fetch after reset
    fetch(16'hF000, 0, a9);                 // HALT
    repeat (20) step(1'($urandom_range(0, 1)), rnd16(), 1'b0);

    // Literal expectations for the directed program.
    check("idle_req",   32'(req_hist[a0-1]), 32'h0);
    check("first_req",  32'(req_hist[a0]),   32'h1);
    check("first_pc",   32'(pc_hist[a0]),    32'h0);
    check("ldi_wr_en",  32'(wen_hist[a0+2]), 32'h1);
    check("ldi_wr_addr",32'(wad_hist[a0+2]), 32'hA);
    check("ldi_wr_data",32'(wdt_hist[a0+2]), 32'h003C);
    check("add_rd_a",   32'(rd_hist[a1+2]),  32'h1);
    check("add_rd_b",   32'(rd_hist[a1+3]),  32'h2);
    cnt = 0;
    for (int i = 1; i <= 4; i++) cnt += int'(wen_hist[a1+i]);
    check("add_no_early_wr", 32'(cnt), 32'h0);
    check("add_wr_en",  32'(wen_hist[a1+5]), 32'h1);
    check("add_wr_addr",32'(wad_hist[a1+5]), 32'h3);
    check("add_wr_data",32'(wdt_hist[a1+5]), 32'h0001);
    check("sub_wr_addr",32'(wad_hist[a2+5]), 32'h0);
    check("sub_wr_data",32'(wdt_hist[a2+5]), 32'h0000);
    check("sub_wr_en",  32'(wen_hist[a2+5]), 32'h1);
    check("jmp_no_wr",  32'(wen_hist[a3+1]), 32'h0);
    check("jmp_pc",     32'(pc_hist[a3+2]),  32'h80);
    cnt = 0;
    for (int i = 0; i <= 4; i++) cnt += int'(req_hist[a4-i] && pc_hist[a4-i] == 8'h80);
    check("stall_hold", 32'(cnt), 32'h5);
    check("ill_pulse",  32'(ill_hist[a4+1]), 32'h1);
    cnt = 0;
    for (int i = 0; i <= 2; i++) cnt += int'(ill_hist[a4+i]);
    check("ill_one_cycle", 32'(cnt), 32'h1);
    check("ill_no_wr",  32'(wen_hist[a4+1]), 32'h0);
    check("ill_next_pc",32'(pc_hist[a4+2]),  32'h81);
    check("wrap_pc_ff", 32'(pc_hist[a6]),    32'hFF);
    check("wrap_pc_00", 32'(pc_hist[a6+2]),  32'h00);
    check("restart_pc", 32'(pc_hist[a8]),    32'h00);
    cnt = 0;
    for (int i = 2; i <= 20; i++) cnt += int'(hlt_hist[a9+i] && !req_hist[a9+i]);
    check("halt_hold",  32'(cnt), 32'd19);
    check("add_abort_ack", 32'(a7 > a6), 32'h1);

    // Randomized phase.
    @(negedge clk);
    reset_pulse("reset2");
    halt_cnt = 0;
    for (int n = 0; n < 2500; n++) begin
      step(1'($urandom_range(0, 99) < 70), rnd_instr(), 1'($urandom_range(0, 7) == 0));
      if (m_halted && q.size() == 0) halt_cnt++;
      if (halt_cnt > 6) begin
        halt_cnt = 0;
        reset_pulse("halt_reset");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameters SHALL be: ADDRESS_LEN, 4, register address width; DATA_LEN, 16, data/instruction width; PC_LEN, 8, program counter width.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction fetch request.
REQ-005 imem_ack  input  1  fetch data valid this cycle.
REQ-006 imem_data  input  DATA_LEN  fetched instruction.
REQ-007 pc  output  PC_LEN  address of instruction being fetched.
REQ-008 rf_rd_addr  output  ADDRESS_LEN  register-file read address (combinational read data expected).
REQ-009 rf_rd_data  input  DATA_LEN  register-file read data.
REQ-010 rf_wr_en / rf_wr_addr / rf_wr_data  output  1 / ADDRESS_LEN / DATA_LEN  register-file write port.
REQ-011 halted  output  1  high while in HALTED state.
REQ-012 illegal  output  1  one-cycle pulse on undefined opcode.

Function
REQ-013 Instruction format SHALL be op[15:12], rd[11:8], rs[7:4], rt[3:0], imm8[7:0].
REQ-014 Opcodes SHALL be: 0x0 NOP; 0x1 ADD rd=rs+rt; 0x2 SUB rd=rs-rt; 0x3 AND; 0x4 OR; 0x5 LDI rd={8'h00,imm8}; 0x6 JMP pc=imm8; 0xF HALT; all others illegal.
REQ-015 States SHALL be IDLE, FETCH, DECODE, READ_A, READ_B, EXEC, WB, HALTED; all outputs Moore (state/register driven).
REQ-016 IDLE -> FETCH unconditionally after one cycle.
REQ-017 FETCH: imem_req=1, pc stable; stay until imem_ack=1; on ack cycle latch imem_data into instruction register, pc <= pc+1, go DECODE.
REQ-018 imem_ack outside FETCH SHALL be ignored.
REQ-019 DECODE: ALU ops -> READ_A; LDI -> WB with result={8'h00,imm8}; JMP -> pc<=imm8, FETCH; HALT -> HALTED; NOP -> FETCH; illegal -> illegal=1 for this cycle only, then FETCH (treated as NOP).
REQ-020 READ_A: rf_rd_addr=rs, operand A <= rf_rd_data; -> READ_B.
REQ-021 READ_B: rf_rd_addr=rt, operand B <= rf_rd_data; -> EXEC.
REQ-022 EXEC: result <= A op B; -> WB.
REQ-023 Arithmetic SHALL wrap modulo 2^DATA_LEN; no carry/overflow output.
REQ-024 WB: rf_wr_en=1 exactly one cycle, rf_wr_addr=rd, rf_wr_data=result; -> FETCH.
REQ-025 rf_wr_en SHALL be 0 in every state except WB; rd=0 is written like any other register.
REQ-026 rs==rt and rd==rs/rt SHALL be legal; operands are captured before writeback.
REQ-027 pc SHALL wrap 0xFF -> 0x00 on increment.
REQ-028 HALTED: halted=1, imem_req=0, rf_wr_en=0; remain until reset.
REQ-029 Latency with imem_ack in first FETCH cycle: ALU op 6 cycles, LDI 3, JMP/NOP/illegal 2 (FETCH to next FETCH).
REQ-030 rf_rd_addr outside READ_A/READ_B SHALL be 0.

Reset
REQ-031 While rst=0: state=IDLE, pc=0, instruction/A/B/result registers=0, imem_req=0, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, rf_rd_addr=0, halted=0, illegal=0.
REQ-032 Reset asserted mid-instruction (any state, including WB or HALTED) SHALL abort immediately with no further rf write; first fetch after release is at pc=0.

Verification
REQ-033 Reset release, imem_ack held 1, imem_data=0x5A3C (LDI r10,0x3C) -> imem_req rises 1 cycle after release, pc=0; WB cycle shows rf_wr_en=1, addr=0xA, data=0x003C.
REQ-034 r1=0xFFFF, r2=0x0002, instr 0x1312 (ADD r3,r1,r2) -> rf_rd_addr 1 then 2, write addr=3 data=0x0001 exactly 5 cycles after ack cycle.
REQ-035 Instr 0x2011 with r1=0x1234 (SUB r0,r1,r1) -> write r0=0x0000; 0x6080 (JMP 0x80) -> next fetch pc=0x80, no write.
REQ-036 imem_ack withheld 4 cycles in FETCH -> imem_req stays 1, pc unchanged; instr 0x7000 -> illegal pulse of 1 cycle, no write, next pc=prev+1; fetch at pc=0xFF -> next pc=0x00.
REQ-037 Instr 0xF000 -> halted=1, imem_req=0 indefinitely; rst pulsed low during WB of an ADD -> rf_wr_en drops same cycle, all outputs at reset values, restart fetch at pc=0.
